// File: rtl/imm_encoder.sv
// imm_encoder: inverse of the immediate extender. Scatters a 32-bit
// immediate into the immediate fields of an RV32I instruction template,
// flags values that the selected format cannot represent, and keeps
// delivery statistics. Two-stage valid/ready pipeline, 1 word/cycle.
//
// Build option: define IMM_ERR_NOP_EN to replace any out-of-range
// encoding with the canonical NOP (addi x0,x0,0) instead of the
// truncated encoding. range_err and err_count behave the same either way.

`default_nettype none

module imm_encoder #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       imm_src,
    input  logic [31:0]      imm_in,
    input  logic [31:0]      base_instr,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr_out,
    output logic             range_err,

    output logic [CNT_W-1:0] enc_count,
    output logic [ERR_W-1:0] err_count
);

    // Immediate format codes, shared with the extender.
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_J = 3'b010,
        IMM_B = 3'b011,
        IMM_U = 3'b100
    } imm_type_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic             s1_valid_q;
    logic [2:0]       s1_src_q;
    logic [31:0]      s1_imm_q;
    logic [31:0]      s1_base_q;

    logic             s2_valid_q;
    logic [31:0]      s2_instr_q;
    logic             s2_err_q;

    logic [CNT_W-1:0] enc_count_q;
    logic [CNT_W-1:0] enc_count_d;
    logic [ERR_W-1:0] err_count_q;
    logic [ERR_W-1:0] err_count_d;

    logic             s1_load;
    logic             s2_load;
    logic             in_xfer;
    logic             out_xfer;

    logic [31:0]      enc_word;
    logic             enc_err;
    logic [31:0]      s2_instr_d;
    logic             s2_err_d;

    // Sign-extension checks: an immediate fits a format when all bits
    // from its top encoded bit upward are copies of the sign.
    logic             fits_12;
    logic             fits_13;
    logic             fits_21;

    // ------------------------------------------------------------------
    // Handshake / stall control
    // ------------------------------------------------------------------

    // Stage loads are pure functions of downstream state and out_ready.
    always_comb begin
        s2_load  = !s2_valid_q || out_ready;
        s1_load  = !s1_valid_q || s2_load;
        in_xfer  = in_valid && s1_load;
        out_xfer = s2_valid_q && out_ready;
    end

    assign in_ready  = s1_load;
    assign out_valid = s2_valid_q;
    assign instr_out = s2_instr_q;
    assign range_err = s2_err_q;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

    // ------------------------------------------------------------------
    // Stage 1: capture the request
    // ------------------------------------------------------------------

    // S1 registers; payload is sampled only on an accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_src_q   <= '0;
            s1_imm_q   <= '0;
            s1_base_q  <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_src_q  <= imm_src;
                s1_imm_q  <= imm_in;
                s1_base_q <= base_instr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Encoder (operates on S1 contents)
    // ------------------------------------------------------------------

    // Range predicates for the three signed immediate widths.
    always_comb begin
        fits_12 = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
        fits_13 = (&s1_imm_q[31:12]) || !(|s1_imm_q[31:12]);
        fits_21 = (&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]);
    end

    // Overlay the immediate fields of the selected format onto the template.
    always_comb begin
        enc_word = s1_base_q;
        enc_err  = 1'b0;
        case (s1_src_q)
            IMM_I: begin
                enc_word[31:20] = s1_imm_q[11:0];
                enc_err         = !fits_12;
            end
            IMM_S: begin
                enc_word[31:25] = s1_imm_q[11:5];
                enc_word[11:7]  = s1_imm_q[4:0];
                enc_err         = !fits_12;
            end
            IMM_J: begin
                enc_word[31]    = s1_imm_q[20];
                enc_word[30:21] = s1_imm_q[10:1];
                enc_word[20]    = s1_imm_q[11];
                enc_word[19:12] = s1_imm_q[19:12];
                enc_err         = !fits_21 || s1_imm_q[0];
            end
            IMM_B: begin
                enc_word[31]    = s1_imm_q[12];
                enc_word[30:25] = s1_imm_q[10:5];
                enc_word[11:8]  = s1_imm_q[4:1];
                enc_word[7]     = s1_imm_q[11];
                enc_err         = !fits_13 || s1_imm_q[0];
            end
            IMM_U: begin
                enc_word[31:12] = s1_imm_q[31:12];
                enc_err         = |s1_imm_q[11:0];
            end
            default: begin
                // Unknown format: template passes through untouched.
                enc_word = s1_base_q;
                enc_err  = 1'b1;
            end
        endcase
    end

    // Select what an erroneous word looks like on the output.
    always_comb begin
        s2_err_d   = enc_err;
`ifdef IMM_ERR_NOP_EN
        s2_instr_d = enc_err ? NOP_INSTR : enc_word;
`else
        s2_instr_d = enc_word;
`endif
    end

    // ------------------------------------------------------------------
    // Stage 2: output register
    // ------------------------------------------------------------------

    // S2 registers; data only moves when a valid S1 word advances, so the
    // presented word is stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_q <= s2_instr_d;
                s2_err_q   <= s2_err_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------

    // Next counter values: delivered count wraps, error count saturates.
    always_comb begin
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (out_xfer) begin
            enc_count_d = enc_count_q + CNT_W'(1);
            if (s2_err_q && (err_count_q != '1)) begin
                err_count_d = err_count_q + ERR_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    // Packed-away unused reference for NOP constant in default builds.
    logic unused_nop;
    assign unused_nop = ^NOP_INSTR;

endmodule

`default_nettype wire

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate extender: takes a 32-bit signed/raw immediate plus an immSrc type code and scatters it into the immediate bit positions of an RV32I instruction word.
- Used by the test-program loader and the self-modifying-code / branch-patch path to build instruction words before they are written to instruction memory.
- Two-stage valid/ready pipeline with range checking and statistics counters.

Parameters:
- CNT_W, 16, width of the wrapping encoded-instruction counter.
- ERR_W, 8, width of the saturating range-error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request this cycle.
- imm_src  input  3  immediate type: 000 I, 001 S, 010 J, 011 B, 100 U. Same coding as the extender.
- imm_in  input  32  immediate value (sign-extended byte offset for I/S/J/B; upper-aligned value for U).
- base_instr  input  32  instruction template; supplies all non-immediate bits (opcode, rd, rs1, rs2, funct).
- out_valid  output  1  encoded word valid.
- out_ready  input  1  downstream accepts word.
- instr_out  output  32  encoded instruction.
- range_err  output  1  qualifies instr_out: immediate not representable for the type.
- enc_count  output  CNT_W  words delivered (wraps).
- err_count  output  ERR_W  words delivered with range_err=1 (saturates at all-ones).

Behaviour:
- Reset (async, rst=1): out_valid=0, instr_out=0, range_err=0, enc_count=0, err_count=0, all stage valids=0. in_ready=1 the first cycle after reset deasserts.
- Transfers:
  - Input transfer occurs when in_valid&in_ready.
  - Output transfer occurs when out_valid&out_ready.
  - Inputs are sampled only on an input transfer.
- Stage 1 (S1): registers imm_src, imm_in and base_instr.
- Stage 2 (S2): registers the encoded word and range_err. The S2 registers drive instr_out, range_err and out_valid.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 word/cycle.
- Stall rules:
  - S2 loads when !out_valid | out_ready.
  - S1 loads when !s1_valid | S2 loads.
  - in_ready = !s1_valid | S2 loads. This is combinational from out_ready; it never depends on in_valid.
- Under stall, instr_out and range_err hold stable while out_valid=1.
- Encoding: start from base_instr, then overwrite the immediate bits by type:
  - I: [31:20]=imm[11:0]. Error if imm[31:11] not all equal.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Error if imm[31:11] not all equal.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. Error if imm[31:20] not all equal or imm[0]=1.
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. Error if imm[31:12] not all equal or imm[0]=1.
  - U: [31:12]=imm[31:12]. Error if imm[11:0]!=0.
  - Other codes (101–111): instr_out=base_instr unchanged, range_err=1.
- On error (without the optional feature), the truncated encoding above is still output.
- Counters:
  - enc_count increments on each output transfer and wraps at 2^CNT_W.
  - err_count increments on each output transfer with range_err=1 and holds at max.
- Reset mid-operation: in-flight words are discarded; no partial output.

Optional Feature:
- Macro: IMM_ERR_NOP_EN.
- Defined: when range_err=1, instr_out is forced to 32'h00000013 (addi x0,x0,0). range_err is still asserted and err_count still counts.
- Undefined: instr_out carries the truncated encoding as specified above.

Test Plan:
- I-type, base 32'h00000093, imm 32'hFFFFFFFF, out_ready=1 -> 2 cycles later instr_out=32'hFFF00093, range_err=0, enc_count=1.
- B-type, base 32'h00000063, imm 32'hFFFFFFFC (-4) -> instr_out=32'hFE000EE3, range_err=0.
- J-type, imm 32'h00000003 (odd) -> range_err=1, err_count=1. With IMM_ERR_NOP_EN, instr_out=32'h00000013.
- U-type, base 32'h00000037, imm 32'h12345000 -> instr_out=32'h12345037. Then imm 32'h12345001 -> range_err=1.
- Backpressure: 4 back-to-back requests with out_ready=0 -> in_ready drops after 2 accepted and instr_out holds. Then out_ready=1 -> all 4 delivered in order, 1/cycle, enc_count=4.
- Assert rst with 2 words in flight -> out_valid=0 immediately (async), counters=0, no stale word after release.
